// File: rtl/hack_fetch_if.sv
// hack_fetch_if: fetch-unit bus bundling the ROM read port, the decoder handshake and the redirect/halt controls.
interface hack_fetch_if #(parameter int ADDR_W = 15);
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_req;
  logic [15:0]       rom_data;
  logic [15:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              jump;
  logic [ADDR_W-1:0] jump_target;
  logic              halt;
  modport master (
    output rom_addr, rom_req, instr, instr_pc, instr_valid,
    input  rom_data, instr_ready, jump, jump_target, halt
  );
  modport slave (
    input  rom_addr, rom_req, instr, instr_pc, instr_valid,
    output rom_data, instr_ready, jump, jump_target, halt
  );
endinterface

// File: rtl/hack_fetch_unit.sv
// hack_fetch_unit: non-pipelined Hack instruction fetch with fixed-latency ROM, valid/ready output and jump redirect.
// Optional HACK_FETCH_PERF_EN adds a saturating fetch_count of accepted instructions.
module hack_fetch_unit #(
  parameter int                ADDR_W      = 15,
  parameter int                ROM_LATENCY = 1,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic            clk,
  input  logic            rst,
  hack_fetch_if.master    io_fetch
`ifdef HACK_FETCH_PERF_EN
  ,
  output logic [15:0]     fetch_count
`endif
);
  localparam logic [1:0] ISSUE  = 2'd0;
  localparam logic [1:0] WAIT   = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;
  localparam logic [1:0] LAT_M1 = 2'(ROM_LATENCY - 1);

  logic [ADDR_W-1:0] r_pc;
  logic [1:0]        r_state;
  logic [1:0]        r_cnt;
  logic [15:0]       r_instr;
  logic [ADDR_W-1:0] r_instr_pc;
  logic              r_valid;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_pc       <= RESET_PC;
      r_state    <= ISSUE;
      r_cnt      <= '0;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
    end else if (io_fetch.jump) begin
      r_pc    <= io_fetch.jump_target;
      r_valid <= 1'b0;
      r_cnt   <= '0;
      r_state <= ISSUE;
    end else if (r_state == ISSUE) begin
      if (!io_fetch.halt) begin
        r_cnt   <= LAT_M1;
        r_state <= WAIT;
      end
    end else if (r_state == WAIT) begin
      if (r_cnt == '0) begin
        r_instr    <= io_fetch.rom_data;
        r_instr_pc <= r_pc;
        r_valid    <= 1'b1;
        r_state    <= HOLD;
      end else
        r_cnt <= r_cnt - 1'b1;
    end else if (r_state == HOLD) begin
      if (io_fetch.instr_ready) begin
        r_pc    <= r_pc + 1'b1;
        r_valid <= 1'b0;
        r_state <= ISSUE;
      end
    end else
      r_state <= ISSUE;

  assign io_fetch.rom_addr    = r_pc;
  assign io_fetch.rom_req     = ~rst & (r_state == ISSUE) & ~io_fetch.halt;
  assign io_fetch.instr       = r_instr;
  assign io_fetch.instr_pc    = r_instr_pc;
  assign io_fetch.instr_valid = r_valid;

`ifdef HACK_FETCH_PERF_EN
  logic [15:0] r_fc;
  // r_valid is only ever set in HOLD, so valid & ready is exactly the handshake, jump or not
  always_ff @(posedge clk or posedge rst)
    if (rst)
      r_fc <= '0;
    else if (r_valid && io_fetch.instr_ready && r_fc != 16'hFFFF)
      r_fc <= r_fc + 1'b1;
  assign fetch_count = r_fc;
`endif
endmodule

// File: tb/tb_hack_fetch_unit.sv
// tb_hack_fetch_unit: directed vector table, hand sequences and a randomized run against a transaction-level model.
module tb_hack_fetch_unit;
  localparam int LAT = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hack_fetch_if #(.ADDR_W(15)) bus ();
`ifdef HACK_FETCH_PERF_EN
  logic [15:0] fetch_count;
`endif

  hack_fetch_unit #(.ADDR_W(15), .ROM_LATENCY(LAT), .RESET_PC(15'd0)) dut (
    .clk(clk),
    .rst(rst),
    .io_fetch(bus)
`ifdef HACK_FETCH_PERF_EN
    ,
    .fetch_count(fetch_count)
`endif
  );

  function automatic logic [15:0] rom_f(input logic [14:0] a);
    return 16'(({1'b0, a} * 16'd40503) ^ 16'h1357);
  endfunction

  logic [15:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= rom_f(bus.rom_addr);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.rom_data = pipe[LAT-1];

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit rdy, input bit jmp, input bit hlt, input logic [14:0] tgt);
    bus.instr_ready = rdy;
    bus.jump = jmp;
    bus.halt = hlt;
    bus.jump_target = tgt;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input bit req, input logic [14:0] addr, input bit v, input logic [14:0] ipc);
    chk({tag, "_req"}, 32'(bus.rom_req), 32'(req));
    chk({tag, "_addr"}, 32'(bus.rom_addr), 32'(addr));
    chk({tag, "_valid"}, 32'(bus.instr_valid), 32'(v));
    chk({tag, "_ipc"}, 32'(bus.instr_pc), 32'(ipc));
    if (v) chk({tag, "_instr"}, 32'(bus.instr), 32'(rom_f(ipc)));
  endtask

  // transaction-level model: pc follows jumps and accepted instructions, data must match ROM contents
  bit          mon_on = 1'b0;
  logic [14:0] exp_pc;
  int          cyc, last_req, hs;
  bit          prev_v, jumped;
  always @(negedge clk) if (mon_on) begin
    cyc++;
    chk("m_addr", 32'(bus.rom_addr), 32'(exp_pc));
    if (jumped) chk("m_jump_kill", 32'(bus.instr_valid), 32'd0);
    if (bus.halt) chk("m_halt_req", 32'(bus.rom_req), 32'd0);
    if (bus.instr_valid && !prev_v) chk("m_latency", 32'(cyc - last_req), 32'(LAT + 1));
    if (bus.instr_valid && bus.instr_ready) begin
      chk("m_ipc", 32'(bus.instr_pc), 32'(exp_pc));
      chk("m_instr", 32'(bus.instr), 32'(rom_f(bus.instr_pc)));
      hs++;
    end
    if (bus.rom_req) last_req = cyc;
    prev_v = bus.instr_valid;
    jumped = bus.jump;
    if (bus.jump) exp_pc = bus.jump_target;
    else if (bus.instr_valid && bus.instr_ready) exp_pc = exp_pc + 15'd1;
  end

  typedef struct {
    bit          rdy, jmp, hlt;
    logic [14:0] tgt;
    bit          req;
    logic [14:0] addr;
    bit          v;
    logic [14:0] ipc;
  } vec_t;
  vec_t vt [24];

  initial begin
    vt[0]  = '{1,0,0,15'h0,    1,15'h0,   0,15'h0};
    vt[1]  = '{1,0,0,15'h0,    0,15'h0,   0,15'h0};
    vt[2]  = '{1,0,0,15'h0,    0,15'h0,   1,15'h0};
    vt[3]  = '{1,0,0,15'h0,    1,15'h1,   0,15'h0};
    vt[4]  = '{1,0,0,15'h0,    0,15'h1,   0,15'h0};
    vt[5]  = '{1,0,0,15'h0,    0,15'h1,   1,15'h1};
    vt[6]  = '{1,0,0,15'h0,    1,15'h2,   0,15'h1};
    vt[7]  = '{1,1,0,15'h100,  0,15'h2,   0,15'h1};
    vt[8]  = '{1,0,0,15'h0,    1,15'h100, 0,15'h1};
    vt[9]  = '{1,0,0,15'h0,    0,15'h100, 0,15'h1};
    vt[10] = '{1,1,0,15'h20,   0,15'h100, 1,15'h100};
    vt[11] = '{1,0,0,15'h0,    1,15'h20,  0,15'h100};
    vt[12] = '{1,0,0,15'h0,    0,15'h20,  0,15'h100};
    vt[13] = '{1,1,0,15'h7FFF, 0,15'h20,  1,15'h20};
    vt[14] = '{1,0,0,15'h0,    1,15'h7FFF,0,15'h20};
    vt[15] = '{1,0,0,15'h0,    0,15'h7FFF,0,15'h20};
    vt[16] = '{1,0,0,15'h0,    0,15'h7FFF,1,15'h7FFF};
    vt[17] = '{1,0,1,15'h0,    0,15'h0,   0,15'h7FFF};
    vt[18] = '{1,1,1,15'h5,    0,15'h0,   0,15'h7FFF};
    vt[19] = '{1,0,1,15'h0,    0,15'h5,   0,15'h7FFF};
    vt[20] = '{1,0,0,15'h0,    1,15'h5,   0,15'h7FFF};
    vt[21] = '{1,0,0,15'h0,    0,15'h5,   0,15'h7FFF};
    vt[22] = '{1,0,0,15'h0,    0,15'h5,   1,15'h5};
    vt[23] = '{0,0,0,15'h0,    1,15'h6,   0,15'h5};

    drive(0, 0, 0, 15'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(bus.rom_req), 32'd0);
    chk("rst_addr", 32'(bus.rom_addr), 32'd0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_ipc", 32'(bus.instr_pc), 32'd0);
    chk("rst_instr", 32'(bus.instr), 32'd0);
`ifdef HACK_FETCH_PERF_EN
    chk("rst_fc", 32'(fetch_count), 32'd0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      drive(vt[i].rdy, vt[i].jmp, vt[i].hlt, vt[i].tgt);
      chk_out($sformatf("vec%0d", i), vt[i].req, vt[i].addr, vt[i].v, vt[i].ipc);
      if (i < 23) tick();
    end
`ifdef HACK_FETCH_PERF_EN
    chk("fc_table", 32'(fetch_count), 32'd6);
`endif
    tick();

    // backpressure: HOLD with ready low keeps everything frozen and issues nothing
    drive(0, 0, 0, 15'h0);
    chk_out("bp_wait", 0, 15'h6, 0, 15'h5);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 15'h0);
      chk_out($sformatf("bp_hold%0d", i), 0, 15'h6, 1, 15'h6);
      tick();
    end
    drive(1, 0, 0, 15'h0);
    chk_out("bp_accept", 0, 15'h6, 1, 15'h6);
    tick();
    drive(0, 0, 0, 15'h0);
    chk_out("bp_next", 1, 15'h7, 0, 15'h6);
    tick();

    // asynchronous reset in the middle of WAIT
    drive(0, 0, 0, 15'h0);
    chk_out("mid_wait", 0, 15'h7, 0, 15'h6);
    rst = 1'b1;
    #1;
    chk("mrst_req", 32'(bus.rom_req), 32'd0);
    chk("mrst_addr", 32'(bus.rom_addr), 32'd0);
    chk("mrst_valid", 32'(bus.instr_valid), 32'd0);
    chk("mrst_ipc", 32'(bus.instr_pc), 32'd0);
    chk("mrst_instr", 32'(bus.instr), 32'd0);
    tick();
    rst = 1'b0;
    drive(1, 0, 0, 15'h0);
    chk_out("restart_issue", 1, 15'h0, 0, 15'h0);
    tick();
    tick();
    drive(1, 0, 0, 15'h0);
    chk_out("restart_hold", 0, 15'h0, 1, 15'h0);
    tick();

    // randomized run against the model
    rst = 1'b1;
    drive(0, 0, 0, 15'h0);
    tick();
    exp_pc = 15'h0;
    cyc = 0;
    last_req = -100;
    hs = 0;
    prev_v = 1'b0;
    jumped = 1'b0;
    rst = 1'b0;
    mon_on = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) == 0 ? 15'h7FFF : 15'($urandom));
      tick();
    end
    mon_on = 1'b0;
    chk("rand_liveness", 32'(hs >= 100), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
